// File: rtl/ysyx_22050710_csr_seq.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_csr_seq
//
// Multi-cycle sequencer that sits between instruction decode and the CSR
// register file. It takes one decoded system instruction (CSRRW, CSRRS,
// CSRRC, ECALL, MRET) through a valid/ready handshake. It walks the CSR
// file's read port and single write port over a few cycles. It then hands
// the rd writeback value and any PC redirect to writeback through a second
// valid/ready handshake.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     decode handshake; o_ready is high only in IDLE
//   i_op                  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET, 5-7 reserved
//   i_csr_addr, i_src     CSR address and rs1 value
//   i_rs1_idx, i_rd       rs1 index (write suppression) and destination GPR
//   i_pc                  PC of the instruction
//   o_csr_ren/o_csr_raddr CSR read port; i_csr_rdata returns combinationally
//   o_csr_wen/o_csr_waddr/o_csr_wdata  CSR write port, written on posedge
//   o_resp_valid / i_resp_ready        writeback handshake
//   o_rd_wen, o_rd, o_rd_data          GPR writeback of the old CSR value
//   o_redirect, o_nextpc               PC redirect for ECALL / MRET
//   o_illegal                          illegal CSR address or reserved op
//
// Every output is a register. Each output is loaded on the edge that
// enters the state in which it must be visible.
// ----------------------------------------------------------------------------
module ysyx_22050710_csr_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_csr_addr,
    input  logic [DATA_WIDTH-1:0] i_src,
    input  logic [4:0]            i_rs1_idx,
    input  logic [4:0]            i_rd,
    input  logic [63:0]           i_pc,

    output logic                  o_csr_ren,
    output logic [ADDR_WIDTH-1:0] o_csr_raddr,
    input  logic [DATA_WIDTH-1:0] i_csr_rdata,

    output logic                  o_csr_wen,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr,
    output logic [DATA_WIDTH-1:0] o_csr_wdata,

    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic                  o_rd_wen,
    output logic [4:0]            o_rd,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_redirect,
    output logic [63:0]           o_nextpc,
    output logic                  o_illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        WRITE2 = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] CSR_MTVEC   = ADDR_WIDTH'(12'h305);
    localparam logic [ADDR_WIDTH-1:0] CSR_MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE  = ADDR_WIDTH'(12'h342);

    // mcause value for an environment call from M-mode
    localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL_M = DATA_WIDTH'(11);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic csr_supported(input logic [ADDR_WIDTH-1:0] a);
        return (a == CSR_MSTATUS) || (a == CSR_MTVEC) ||
               (a == CSR_MEPC)    || (a == CSR_MCAUSE);
    endfunction

    // ECALL reads mtvec (the trap target); MRET reads mepc (the return PC).
    function automatic logic [ADDR_WIDTH-1:0] read_addr(
        input logic [2:0]            op,
        input logic [ADDR_WIDTH-1:0] a
    );
        case (op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: return a;
            OP_ECALL:                     return CSR_MTVEC;
            OP_MRET:                      return CSR_MEPC;
            default:                      return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rmw_data(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] src
    );
        case (op)
            OP_CSRRS: return old | src;
            OP_CSRRC: return old & ~src;
            default:  return src;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State and instruction latches
    // ------------------------------------------------------------------------
    state_t                  state;
    logic [2:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   src_q;
    logic [4:0]              rs1_q;
    logic [4:0]              rd_q;
    logic [63:0]             pc_q;
    logic [DATA_WIDTH-1:0]   old_q;

    // ------------------------------------------------------------------------
    // Decode of the latched instruction and the response it will produce
    // ------------------------------------------------------------------------
    logic                    is_csr_op;
    logic                    op_illegal;
    logic                    skip_write;
    logic                    enter_resp;
    logic [DATA_WIDTH-1:0]   resp_old;
    logic                    resp_rd_wen;
    logic [DATA_WIDTH-1:0]   resp_rd_data;
    logic                    resp_redirect;
    logic [63:0]             resp_nextpc;

    always_comb begin
        is_csr_op  = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
        op_illegal = (op_q > OP_MRET) || (is_csr_op && !csr_supported(addr_q));
        // Set/clear with x0 as the source is a pure read.
        skip_write = ((op_q == OP_CSRRS) || (op_q == OP_CSRRC)) && (rs1_q == 5'd0);

        enter_resp = 1'b0;
        case (state)
            READ:    enter_resp = op_illegal || (op_q == OP_MRET) || skip_write;
            WRITE:   enter_resp = (op_q != OP_ECALL);
            WRITE2:  enter_resp = 1'b1;
            default: enter_resp = 1'b0;
        endcase

        // Leaving READ, the old value has not reached old_q yet, so
        // take it straight from the read port.
        resp_old      = (state == READ) ? i_csr_rdata : old_q;
        resp_rd_wen   = is_csr_op && !op_illegal && (rd_q != 5'd0);
        resp_rd_data  = (is_csr_op && !op_illegal) ? resp_old : '0;
        resp_redirect = !op_illegal && ((op_q == OP_ECALL) || (op_q == OP_MRET));
        resp_nextpc   = resp_redirect ? 64'(resp_old) : 64'd0;
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            src_q        <= '0;
            rs1_q        <= '0;
            rd_q         <= '0;
            pc_q         <= '0;
            old_q        <= '0;
            o_ready      <= 1'b1;
            o_csr_ren    <= 1'b0;
            o_csr_raddr  <= '0;
            o_csr_wen    <= 1'b0;
            o_csr_waddr  <= '0;
            o_csr_wdata  <= '0;
            o_resp_valid <= 1'b0;
            o_rd_wen     <= 1'b0;
            o_rd         <= '0;
            o_rd_data    <= '0;
            o_redirect   <= 1'b0;
            o_nextpc     <= '0;
            o_illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q        <= i_op;
                        addr_q      <= i_csr_addr;
                        src_q       <= i_src;
                        rs1_q       <= i_rs1_idx;
                        rd_q        <= i_rd;
                        pc_q        <= i_pc;
                        o_ready     <= 1'b0;
                        o_csr_ren   <= 1'b1;
                        o_csr_raddr <= read_addr(i_op, i_csr_addr);
                        state       <= READ;
                    end
                end

                READ: begin
                    old_q       <= i_csr_rdata;
                    o_csr_ren   <= 1'b0;
                    o_csr_raddr <= '0;
                    if (enter_resp) begin
                        state <= RESP;
                    end else begin
                        o_csr_wen <= 1'b1;
                        if (op_q == OP_ECALL) begin
                            o_csr_waddr <= CSR_MEPC;
                            o_csr_wdata <= DATA_WIDTH'(pc_q);
                        end else begin
                            o_csr_waddr <= addr_q;
                            o_csr_wdata <= rmw_data(op_q, i_csr_rdata, src_q);
                        end
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    if (op_q == OP_ECALL) begin
                        // Second write of the trap entry: record the cause.
                        o_csr_waddr <= CSR_MCAUSE;
                        o_csr_wdata <= CAUSE_ECALL_M;
                        state       <= WRITE2;
                    end else begin
                        o_csr_wen   <= 1'b0;
                        o_csr_waddr <= '0;
                        o_csr_wdata <= '0;
                        state       <= RESP;
                    end
                end

                WRITE2: begin
                    o_csr_wen   <= 1'b0;
                    o_csr_waddr <= '0;
                    o_csr_wdata <= '0;
                    state       <= RESP;
                end

                RESP: begin
                    // The response is held until writeback takes it. IDLE
                    // follows, so the next accept is one cycle later.
                    if (i_resp_ready) begin
                        o_resp_valid <= 1'b0;
                        o_rd_wen     <= 1'b0;
                        o_rd         <= '0;
                        o_rd_data    <= '0;
                        o_redirect   <= 1'b0;
                        o_nextpc     <= '0;
                        o_illegal    <= 1'b0;
                        o_ready      <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    o_csr_ren    <= 1'b0;
                    o_csr_raddr  <= '0;
                    o_csr_wen    <= 1'b0;
                    o_csr_waddr  <= '0;
                    o_csr_wdata  <= '0;
                    o_resp_valid <= 1'b0;
                    o_ready      <= 1'b1;
                    state        <= IDLE;
                end
            endcase

            // Load the response registers on the edge that enters RESP.
            if (enter_resp) begin
                o_resp_valid <= 1'b1;
                o_rd_wen     <= resp_rd_wen;
                o_rd         <= rd_q;
                o_rd_data    <= resp_rd_data;
                o_redirect   <= resp_redirect;
                o_nextpc     <= resp_nextpc;
                o_illegal    <= op_illegal;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_csr_seq.sv
module tb_ysyx_22050710_csr_seq;

    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [2:0]    op;
    logic [AW-1:0] csr_addr;
    logic [DW-1:0] src;
    logic [4:0]    rs1_idx;
    logic [4:0]    rd;
    logic [63:0]   pc;
    logic          csr_ren;
    logic [AW-1:0] csr_raddr;
    logic [DW-1:0] csr_rdata;
    logic          csr_wen;
    logic [AW-1:0] csr_waddr;
    logic [DW-1:0] csr_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          rd_wen;
    logic [4:0]    rd_out;
    logic [DW-1:0] rd_data;
    logic          redirect;
    logic [63:0]   nextpc;
    logic          illegal;

    always #5 clk = ~clk;

    ysyx_22050710_csr_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid(valid), .o_ready(ready),
        .i_op(op), .i_csr_addr(csr_addr), .i_src(src),
        .i_rs1_idx(rs1_idx), .i_rd(rd), .i_pc(pc),
        .o_csr_ren(csr_ren), .o_csr_raddr(csr_raddr), .i_csr_rdata(csr_rdata),
        .o_csr_wen(csr_wen), .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_rd_wen(rd_wen), .o_rd(rd_out), .o_rd_data(rd_data),
        .o_redirect(redirect), .o_nextpc(nextpc), .o_illegal(illegal)
    );

    logic [226:0] outs;
    assign outs = {csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata, resp_valid,
                   rd_wen, rd_out, rd_data, redirect, nextpc, illegal};

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    // CSR register file seen by the DUT
    logic [63:0] csr_file [4];
    logic        preset_en = 1'b0;
    int          preset_k  = 0;
    logic [63:0] preset_v  = '0;

    always_comb begin : rd_mux
        int k;
        k = csr_idx(csr_raddr);
        if (k < 0) csr_rdata = 64'hbad0_bad0_bad0_bad0;
        else       csr_rdata = csr_file[k];
    end

    always @(posedge clk) begin
        if (preset_en) csr_file[preset_k] <= preset_v;
        else if (csr_wen && csr_idx(csr_waddr) >= 0) csr_file[csr_idx(csr_waddr)] <= csr_wdata;
    end

    // Reference: architectural CSR state plus the expected outcome per instruction
    logic [63:0] ref_csr [4];
    int          exp_lat, exp_nwr;
    logic [11:0] exp_wa [2];
    logic [63:0] exp_wd [2];
    logic        exp_rd_wen, exp_redirect, exp_illegal, exp_csr_ok;
    logic [63:0] exp_rd_data, exp_nextpc;

    task automatic model(input logic [2:0] t_op, input logic [11:0] t_addr, input logic [63:0] t_src,
                         input logic [4:0] t_rs1, input logic [4:0] t_rd, input logic [63:0] t_pc);
        int k;
        logic [63:0] old;
        k = csr_idx(t_addr);
        exp_nwr = 0; exp_rd_wen = 0; exp_rd_data = 0; exp_redirect = 0;
        exp_nextpc = 0; exp_illegal = 0; exp_csr_ok = 0;
        if (t_op > 3'd4 || (t_op <= 3'd2 && k < 0)) begin
            exp_illegal = 1; exp_lat = 2;
        end else if (t_op == 3'd3) begin
            exp_lat = 4; exp_redirect = 1; exp_nextpc = ref_csr[1];
            exp_nwr = 2; exp_wa[0] = 12'h341; exp_wd[0] = t_pc; exp_wa[1] = 12'h342; exp_wd[1] = 64'd11;
            ref_csr[2] = t_pc; ref_csr[3] = 64'd11;
        end else if (t_op == 3'd4) begin
            exp_lat = 2; exp_redirect = 1; exp_nextpc = ref_csr[2];
        end else begin
            old = ref_csr[k];
            exp_csr_ok = 1; exp_rd_wen = (t_rd != 0); exp_rd_data = old;
            if (t_op != 3'd0 && t_rs1 == 0) begin
                exp_lat = 2;
            end else begin
                exp_lat = 3; exp_nwr = 1; exp_wa[0] = t_addr;
                if (t_op == 3'd0)      exp_wd[0] = t_src;
                else if (t_op == 3'd1) exp_wd[0] = old | t_src;
                else                   exp_wd[0] = old & ~t_src;
                ref_csr[k] = exp_wd[0];
            end
        end
    endtask

    task automatic preset(input logic [11:0] a, input logic [63:0] v);
        @(negedge clk);
        preset_en = 1; preset_k = csr_idx(a); preset_v = v;
        ref_csr[csr_idx(a)] = v;
        @(posedge clk); @(negedge clk);
        preset_en = 0;
    endtask

    // Observations from one instruction run with i_resp_ready held high
    int          obs_lat, obs_nwr;
    logic        obs_timeout, obs_ready_after;
    logic [11:0] obs_wa [4];
    logic [63:0] obs_wd [4];
    logic [11:0] obs_raddr;
    logic        obs_rd_wen, obs_redirect, obs_illegal;
    logic [4:0]  obs_rd;
    logic [63:0] obs_rd_data, obs_nextpc;

    task automatic run_instr(input logic [2:0] t_op, input logic [11:0] t_addr, input logic [63:0] t_src,
                             input logic [4:0] t_rs1, input logic [4:0] t_rd, input logic [63:0] t_pc);
        @(negedge clk);
        valid = 1; op = t_op; csr_addr = t_addr; src = t_src; rs1_idx = t_rs1; rd = t_rd; pc = t_pc;
        resp_ready = 1;
        obs_lat = 0; obs_nwr = 0; obs_timeout = 1; obs_raddr = '0; obs_ready_after = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 1) valid = 0;
            if (csr_ren) obs_raddr = csr_raddr;
            if (csr_wen) begin
                if (obs_nwr < 4) begin obs_wa[obs_nwr] = csr_waddr; obs_wd[obs_nwr] = csr_wdata; end
                obs_nwr++;
            end
            if (resp_valid) begin
                obs_lat = c; obs_timeout = 0;
                obs_rd_wen = rd_wen; obs_rd = rd_out; obs_rd_data = rd_data;
                obs_redirect = redirect; obs_nextpc = nextpc; obs_illegal = illegal;
                break;
            end
        end
        if (!obs_timeout) begin
            @(posedge clk); @(negedge clk);
            obs_ready_after = ready && !resp_valid;
        end
    endtask

    task automatic test_reset();
        logic [63:0] epc;
        rst = 1; valid = 0; op = 0; csr_addr = 0; src = 0; rs1_idx = 0; rd = 0; pc = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", ready); end
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            preset_en = 1; preset_k = i; preset_v = {$urandom, $urandom}; ref_csr[i] = preset_v;
            @(posedge clk); @(negedge clk);
        end
        preset_en = 0;
        // ECALL interrupted by reset while in WRITE
        epc = 64'h8000_0a00;
        valid = 1; op = 3'd3; pc = epc; resp_ready = 1;
        @(posedge clk); @(negedge clk);
        valid = 0;
        for (int c = 0; c < 10 && !csr_wen; c++) begin @(posedge clk); @(negedge clk); end
        n_chk++; if (csr_wen !== 1'b1) begin n_fail++; $display("FAIL reset_reach_write: got wen %0b expected 1", csr_wen); end
        rst = 1;
        @(posedge clk); @(negedge clk);
        ref_csr[2] = epc;   // the WRITE cycle's mepc write lands on the reset edge
        n_chk++; if (csr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wen: got %0b expected 0", csr_wen); end
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %0b expected 1", ready); end
        n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", outs); end
        @(posedge clk); @(negedge clk);
        rst = 0;
        @(posedge clk); @(negedge clk);
        n_chk++; if (ready !== 1'b1 || outs !== '0) begin n_fail++; $display("FAIL reset_after_idle: ready %0b outs %h expected 1 and 0", ready, outs); end
    endtask

    task automatic test_csrrw();
        preset(12'h305, 64'h0);
        model(3'd0, 12'h305, 64'h8000_0100, 5'd1, 5'd5, 64'h0);
        run_instr(3'd0, 12'h305, 64'h8000_0100, 5'd1, 5'd5, 64'h0);
        n_chk++; if (obs_timeout) begin n_fail++; $display("FAIL csrrw_timeout: got no response expected response"); end
        n_chk++; if (obs_lat !== 3) begin n_fail++; $display("FAIL csrrw_latency: got %0d expected 3", obs_lat); end
        n_chk++; if (obs_nwr !== 1 || obs_wa[0] !== 12'h305 || obs_wd[0] !== 64'h8000_0100)
            begin n_fail++; $display("FAIL csrrw_write: got n=%0d %h=%h expected 1 305=80000100", obs_nwr, obs_wa[0], obs_wd[0]); end
        n_chk++; if (obs_rd_wen !== 1 || obs_rd !== 5'd5 || obs_rd_data !== 64'h0)
            begin n_fail++; $display("FAIL csrrw_resp: got wen=%0b rd=%0d data=%h expected 1 5 0", obs_rd_wen, obs_rd, obs_rd_data); end
        n_chk++; if (obs_ready_after !== 1) begin n_fail++; $display("FAIL csrrw_idle_after: got %0b expected 1", obs_ready_after); end
    endtask

    task automatic test_csrrs();
        preset(12'h300, 64'ha_0000_1800);
        model(3'd1, 12'h300, 64'h8, 5'd3, 5'd7, 64'h0);
        run_instr(3'd1, 12'h300, 64'h8, 5'd3, 5'd7, 64'h0);
        n_chk++; if (obs_lat !== 3 || obs_nwr !== 1 || obs_wd[0] !== 64'ha_0000_1808)
            begin n_fail++; $display("FAIL csrrs_write: got lat=%0d n=%0d wd=%h expected 3 1 a00001808", obs_lat, obs_nwr, obs_wd[0]); end
        n_chk++; if (obs_rd_data !== 64'ha_0000_1800) begin n_fail++; $display("FAIL csrrs_rd_data: got %h expected a00001800", obs_rd_data); end
        model(3'd1, 12'h300, 64'h8, 5'd0, 5'd7, 64'h0);
        run_instr(3'd1, 12'h300, 64'h8, 5'd0, 5'd7, 64'h0);
        n_chk++; if (obs_lat !== 2 || obs_nwr !== 0)
            begin n_fail++; $display("FAIL csrrs_x0: got lat=%0d n=%0d expected 2 0", obs_lat, obs_nwr); end
        n_chk++; if (obs_rd_data !== exp_rd_data) begin n_fail++; $display("FAIL csrrs_x0_data: got %h expected %h", obs_rd_data, exp_rd_data); end
    endtask

    task automatic test_ecall_mret();
        preset(12'h305, 64'h8000_0100);
        model(3'd3, 12'h0, 64'h0, 5'd0, 5'd0, 64'h8000_0040);
        run_instr(3'd3, 12'h0, 64'h0, 5'd0, 5'd0, 64'h8000_0040);
        n_chk++; if (obs_lat !== 4) begin n_fail++; $display("FAIL ecall_latency: got %0d expected 4", obs_lat); end
        n_chk++; if (obs_nwr !== 2 || obs_wa[0] !== 12'h341 || obs_wd[0] !== 64'h8000_0040 || obs_wa[1] !== 12'h342 || obs_wd[1] !== 64'd11)
            begin n_fail++; $display("FAIL ecall_writes: got n=%0d %h=%h %h=%h expected 341=80000040 342=b", obs_nwr, obs_wa[0], obs_wd[0], obs_wa[1], obs_wd[1]); end
        n_chk++; if (obs_redirect !== 1 || obs_nextpc !== 64'h8000_0100 || obs_rd_wen !== 0)
            begin n_fail++; $display("FAIL ecall_redirect: got r=%0b pc=%h wen=%0b expected 1 80000100 0", obs_redirect, obs_nextpc, obs_rd_wen); end
        n_chk++; if (obs_raddr !== 12'h305) begin n_fail++; $display("FAIL ecall_raddr: got %h expected 305", obs_raddr); end
        model(3'd4, 12'h0, 64'h0, 5'd0, 5'd0, 64'h0);
        run_instr(3'd4, 12'h0, 64'h0, 5'd0, 5'd0, 64'h0);
        n_chk++; if (obs_lat !== 2 || obs_nwr !== 0) begin n_fail++; $display("FAIL mret_latency: got lat=%0d n=%0d expected 2 0", obs_lat, obs_nwr); end
        n_chk++; if (obs_redirect !== 1 || obs_nextpc !== 64'h8000_0040)
            begin n_fail++; $display("FAIL mret_redirect: got r=%0b pc=%h expected 1 80000040", obs_redirect, obs_nextpc); end
    endtask

    task automatic test_illegal();
        model(3'd2, 12'h7C0, 64'hff, 5'd2, 5'd4, 64'h0);
        run_instr(3'd2, 12'h7C0, 64'hff, 5'd2, 5'd4, 64'h0);
        n_chk++; if (obs_lat !== 2 || obs_nwr !== 0) begin n_fail++; $display("FAIL illegal_addr_flow: got lat=%0d n=%0d expected 2 0", obs_lat, obs_nwr); end
        n_chk++; if (obs_illegal !== 1 || obs_rd_wen !== 0 || obs_redirect !== 0)
            begin n_fail++; $display("FAIL illegal_addr_resp: got ill=%0b wen=%0b r=%0b expected 1 0 0", obs_illegal, obs_rd_wen, obs_redirect); end
        model(3'd6, 12'h300, 64'h1, 5'd1, 5'd3, 64'h0);
        run_instr(3'd6, 12'h300, 64'h1, 5'd1, 5'd3, 64'h0);
        n_chk++; if (obs_nwr !== 0 || obs_illegal !== 1 || obs_rd_wen !== 0 || obs_redirect !== 0)
            begin n_fail++; $display("FAIL reserved_op: got n=%0d ill=%0b wen=%0b r=%0b expected 0 1 0 0", obs_nwr, obs_illegal, obs_rd_wen, obs_redirect); end
    endtask

    task automatic test_backpressure();
        logic [63:0] first_data, v;
        logic [135:0] snap;
        logic got;
        v = {$urandom, $urandom};
        model(3'd0, 12'h300, v, 5'd1, 5'd9, 64'h0);
        first_data = exp_rd_data;
        @(negedge clk);
        resp_ready = 0; valid = 1; op = 3'd0; csr_addr = 12'h300; src = v; rs1_idx = 1; rd = 9;
        got = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 1) begin op = 3'd1; csr_addr = 12'h342; rs1_idx = 0; rd = 12; end  // queued, valid stays high
            if (resp_valid) begin got = 1; break; end
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL bp_timeout: got no response expected response"); end
        n_chk++; if (rd_data !== first_data || rd_out !== 5'd9) begin n_fail++; $display("FAIL bp_data: got %h rd=%0d expected %h 9", rd_data, rd_out, first_data); end
        snap = {rd_wen, rd_out, rd_data, redirect, nextpc, illegal};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            n_chk++; if (resp_valid !== 1 || ready !== 0 || {rd_wen, rd_out, rd_data, redirect, nextpc, illegal} !== snap)
                begin n_fail++; $display("FAIL bp_hold: cycle %0d valid=%0b ready=%0b data=%h expected 1 0 %h", i, resp_valid, ready, rd_data, first_data); end
        end
        resp_ready = 1;
        @(posedge clk); @(negedge clk);
        n_chk++; if (resp_valid !== 0 || ready !== 1) begin n_fail++; $display("FAIL bp_release: got valid=%0b ready=%0b expected 0 1", resp_valid, ready); end
        model(3'd1, 12'h342, 64'h0, 5'd0, 5'd12, 64'h0);
        @(posedge clk); @(negedge clk);
        valid = 0;
        n_chk++; if (ready !== 0 || csr_ren !== 1 || csr_raddr !== 12'h342)
            begin n_fail++; $display("FAIL bp_queued_accept: got ready=%0b ren=%0b raddr=%h expected 0 1 342", ready, csr_ren, csr_raddr); end
        got = 0;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (resp_valid) begin
                got = 1;
                n_chk++; if (c !== exp_lat || rd_data !== exp_rd_data)
                    begin n_fail++; $display("FAIL bp_queued_resp: got lat=%0d data=%h expected %0d %h", c, rd_data, exp_lat, exp_rd_data); end
                break;
            end
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL bp_queued_timeout: got no response expected response"); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random();
        logic [11:0] addrs [5];
        logic [2:0]  r_op;
        logic [11:0] r_addr;
        logic [63:0] r_src, r_pc;
        logic [4:0]  r_rs1, r_rd;
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;
        for (int n = 0; n < 60; n++) begin
            r_op   = 3'($urandom_range(0, 7));
            addrs[4] = 12'($urandom);
            r_addr = addrs[$urandom_range(0, 4)];
            r_src  = {$urandom, $urandom};
            r_pc   = {$urandom, $urandom};
            r_rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_rd   = 5'($urandom_range(0, 31));
            model(r_op, r_addr, r_src, r_rs1, r_rd, r_pc);
            run_instr(r_op, r_addr, r_src, r_rs1, r_rd, r_pc);
            n_chk++; if (obs_timeout || obs_lat !== exp_lat || obs_nwr !== exp_nwr)
                begin n_fail++; $display("FAIL rand_flow[%0d] op=%0d: got lat=%0d n=%0d expected %0d %0d", n, r_op, obs_lat, obs_nwr, exp_lat, exp_nwr); end
            for (int w = 0; w < exp_nwr && w < obs_nwr; w++) begin
                n_chk++; if (obs_wa[w] !== exp_wa[w] || obs_wd[w] !== exp_wd[w])
                    begin n_fail++; $display("FAIL rand_write[%0d.%0d]: got %h=%h expected %h=%h", n, w, obs_wa[w], obs_wd[w], exp_wa[w], exp_wd[w]); end
            end
            n_chk++; if (obs_rd_wen !== exp_rd_wen || obs_redirect !== exp_redirect || obs_illegal !== exp_illegal)
                begin n_fail++; $display("FAIL rand_flags[%0d] op=%0d: got wen=%0b r=%0b ill=%0b expected %0b %0b %0b", n, r_op, obs_rd_wen, obs_redirect, obs_illegal, exp_rd_wen, exp_redirect, exp_illegal); end
            if (exp_csr_ok) begin
                n_chk++; if (obs_rd_data !== exp_rd_data || obs_rd !== r_rd)
                    begin n_fail++; $display("FAIL rand_rd[%0d]: got rd=%0d data=%h expected %0d %h", n, obs_rd, obs_rd_data, r_rd, exp_rd_data); end
            end
            if (exp_redirect) begin
                n_chk++; if (obs_nextpc !== exp_nextpc)
                    begin n_fail++; $display("FAIL rand_nextpc[%0d]: got %h expected %h", n, obs_nextpc, exp_nextpc); end
            end
            n_chk++; if (obs_ready_after !== 1) begin n_fail++; $display("FAIL rand_idle_after[%0d]: got %0b expected 1", n, obs_ready_after); end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (csr_file[i] !== ref_csr[i])
                begin n_fail++; $display("FAIL rand_csr_state[%0d]: got %h expected %h", i, csr_file[i], ref_csr[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs();
        test_ecall_mret();
        test_illegal();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_csr_seq.md
Name: ysyx_22050710_csr_seq

Overview:
Multi-cycle sequencer between the instruction decode stage and the CSR register file. It accepts one decoded system instruction (CSRRW, CSRRS, CSRRC, ECALL, MRET) through a valid/ready handshake. It then drives the CSR file's read port and single write port over several cycles, and returns the rd writeback value and any PC redirect to writeback through a second handshake.

Parameters:
ADDR_WIDTH, 12, CSR address width
DATA_WIDTH, 64, CSR/GPR data width

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  synchronous active-high reset
i_valid  in  1  decode presents an instruction
o_ready  out  1  sequencer can accept (high only in IDLE)
i_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET; 5-7 reserved
i_csr_addr  in  ADDR_WIDTH  CSR address (CSR ops only)
i_src  in  DATA_WIDTH  rs1 value
i_rs1_idx  in  5  rs1 index, used for write suppression
i_rd  in  5  destination GPR
i_pc  in  64  PC of the instruction
o_csr_ren  out  1  CSR read enable
o_csr_raddr  out  ADDR_WIDTH  CSR read address
i_csr_rdata  in  DATA_WIDTH  combinational read data from the CSR file
o_csr_wen  out  1  CSR write enable; the CSR file writes on posedge
o_csr_waddr  out  ADDR_WIDTH  CSR write address
o_csr_wdata  out  DATA_WIDTH  CSR write data
o_resp_valid  out  1  result available
i_resp_ready  in  1  writeback accepts the result
o_rd_wen  out  1  write o_rd_data to o_rd
o_rd  out  5  latched rd
o_rd_data  out  DATA_WIDTH  old CSR value
o_redirect  out  1  take o_nextpc
o_nextpc  out  64  redirect target
o_illegal  out  1  illegal CSR access or reserved op

Behaviour:
- Reset (i_rst sampled high at posedge): state becomes IDLE and all internal latches clear. Every output except o_ready is 0. o_ready is 1. Reset mid-sequence abandons the instruction; no CSR write occurs in the cycle after reset.
- Supported CSR addresses: 0x300, 0x305, 0x341, 0x342. Any other address is illegal.
- States: IDLE, READ, WRITE, WRITE2, RESP.
- IDLE: o_ready=1. When i_valid is high, latch op, addr, src, rs1_idx, rd and pc, then go to READ. o_ready is 0 in every other state.
- READ (1 cycle): o_csr_ren=1. o_csr_raddr = addr for CSR ops, 0x305 for ECALL, 0x341 for MRET. Capture i_csr_rdata into the old register. Next state:
  - Illegal address or reserved op: RESP with the illegal flag set.
  - MRET: RESP.
  - CSRRS or CSRRC with rs1_idx==0: RESP (no write).
  - Otherwise: WRITE.
- WRITE (1 cycle): o_csr_wen=1.
  - CSRRW: waddr=addr, wdata=src.
  - CSRRS: wdata = old | src.
  - CSRRC: wdata = old & ~src.
  - ECALL: waddr=0x341, wdata=pc, then go to WRITE2. All other ops go to RESP.
- WRITE2 (ECALL only): o_csr_wen=1, waddr=0x342, wdata=11. Next state RESP.
- RESP: o_resp_valid=1, and outputs hold stable until i_resp_ready is high. On that cycle, return to IDLE.
  - CSR ops: o_rd_wen = legal && rd!=0, o_rd_data = old.
  - ECALL: o_redirect=1, o_nextpc = old (mtvec).
  - MRET: o_redirect=1, o_nextpc = old (mepc).
  - Illegal: o_illegal=1, with o_rd_wen, o_redirect and no CSR write all suppressed.
- In any state other than READ/WRITE/WRITE2, o_csr_ren, o_csr_wen, addresses and wdata are driven 0.
- Latency from accept edge to first o_resp_valid cycle:
  - CSRRW and CSRRS/CSRRC with rs1_idx!=0: 3 cycles.
  - ECALL: 4 cycles.
  - MRET, illegal, and CSRRS/CSRRC with rs1_idx==0: 2 cycles.
- Back-to-back: a new instruction can be accepted on the cycle after the RESP handshake, never in the same cycle.
- Inputs are ignored outside IDLE; i_valid may stay high.
- The pc and nextpc arithmetic is pass-through only. No truncation; all fields use their full width.

Test Plan:
- Reset: hold i_rst for 2 cycles mid-ECALL (in WRITE) -> no wen on the next cycle, o_ready=1, all other outputs 0.
- CSRRW to 0x305 with src=0x8000_0100, old=0x0, rd=5 -> WRITE cycle has wen=1, waddr=0x305, wdata=0x80000100. RESP has rd_wen=1, rd=5, rd_data=0 at accept+3.
- CSRRS to 0x300 with old=0xa00001800, src=0x8, rs1_idx=3 -> wdata=0xa00001808, rd_data=0xa00001800. Repeat with rs1_idx=0 -> no wen, RESP at accept+2.
- ECALL at pc=0x80000040 with mtvec=0x80000100 -> WRITE writes 0x341=0x80000040, WRITE2 writes 0x342=11. RESP at accept+4 has redirect=1, nextpc=0x80000100. Then MRET -> redirect=1, nextpc=0x80000040 at accept+2.
- CSRRC to illegal address 0x7C0 -> no wen, RESP has o_illegal=1, rd_wen=0, redirect=0.
- Backpressure: hold i_resp_ready=0 for 5 cycles in RESP -> outputs stable and o_ready=0. Raise i_resp_ready -> IDLE next cycle, and the queued i_valid is accepted one cycle later.
